// File: rtl/vpu_pkg.sv
// Shared VPU constants and stage state encoding.
// The writeback FSM state type is reused by later VPU stages.
package vpu_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned RW    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLAG  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/lane_prio_enc.sv
// Lowest-set-bit priority encoder over a lane mask.
// Purely combinational; idx is 0 when no bit is set.
module lane_prio_enc #(
    parameter int unsigned LANES = vpu_pkg::LANES
) (
    input  logic [LANES-1:0] req,
    output logic [2:0]       idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/vec_writeback.sv
// Vector writeback: captures one ALU result, drains enabled lanes in
// ascending order into the single VRF write port, then commits flags.
module vec_writeback
    import vpu_pkg::*;
#(
    parameter int unsigned LANES = vpu_pkg::LANES,
    parameter int unsigned DW    = vpu_pkg::DW,
    parameter int unsigned RW    = vpu_pkg::RW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANES*DW-1:0] in_data,
    input  logic [LANES-1:0]  in_ng,
    input  logic [LANES-1:0]  in_zr,
    input  logic [LANES-1:0]  in_mask,
    input  logic [RW-1:0]     in_rd,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [RW-1:0]     wr_vreg,
    output logic [2:0]        wr_lane,
    output logic [DW-1:0]     wr_data,
    output logic              fl_we,
    output logic [LANES-1:0]  fl_ng,
    output logic [LANES-1:0]  fl_zr,
    output logic              busy
);

    wb_state_t        state_q;
    logic [LANES-1:0] pend_q;
    logic [LANES-1:0] mask_q;
    logic [LANES-1:0] ng_q;
    logic [LANES-1:0] zr_q;
    logic [RW-1:0]    rd_q;
    logic [DW-1:0]    data_q [LANES];

    logic [2:0]       lane;
    logic             pend_any;
    logic [LANES-1:0] lane_bit;
    logic [LANES-1:0] pend_nx;

    lane_prio_enc #(
        .LANES (LANES)
    ) u_enc (
        .req (pend_q),
        .idx (lane),
        .any (pend_any)
    );

    assign lane_bit = LANES'(1) << lane;
    assign pend_nx  = pend_q & ~lane_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            mask_q  <= '0;
            ng_q    <= '0;
            zr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < LANES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        pend_q <= in_mask;
                        mask_q <= in_mask;
                        ng_q   <= in_ng;
                        zr_q   <= in_zr;
                        rd_q   <= in_rd;
                        for (int i = 0; i < LANES; i++) begin
                            data_q[i] <= in_data[i*DW +: DW];
                        end
                        state_q <= (|in_mask) ? DRAIN : FLAG;
                    end
                end
                DRAIN: begin
                    if (wr_ready) begin
                        pend_q <= pend_nx;
                        if (pend_nx == '0) begin
                            state_q <= FLAG;
                        end
                    end
                end
                FLAG: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // All outputs come from registered state only; nothing from in_* leaks through.
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign wr_valid = (state_q == DRAIN) && pend_any;
    assign wr_lane  = lane;
    assign wr_data  = data_q[lane];
    assign wr_vreg  = rd_q;
    assign fl_we    = (state_q == FLAG);
    assign fl_ng    = fl_we ? (ng_q & mask_q) : '0;
    assign fl_zr    = fl_we ? (zr_q & mask_q) : '0;

endmodule

// File: tb/tb_vec_writeback.sv
// Self-checking bench for vec_writeback: directed table, hand sequences
// for reset/back-to-back, and randomized vectors against a lane-order model.
module tb_vec_writeback;

    localparam int LANES = 8;
    localparam int DW    = 32;
    localparam int RW    = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [LANES*DW-1:0] in_data;
    logic [LANES-1:0]  in_ng;
    logic [LANES-1:0]  in_zr;
    logic [LANES-1:0]  in_mask;
    logic [RW-1:0]     in_rd;
    logic              wr_valid;
    logic              wr_ready;
    logic [RW-1:0]     wr_vreg;
    logic [2:0]        wr_lane;
    logic [DW-1:0]     wr_data;
    logic              fl_we;
    logic [LANES-1:0]  fl_ng;
    logic [LANES-1:0]  fl_zr;
    logic              busy;

    always #5 clk = ~clk;

    vec_writeback #(
        .LANES (LANES),
        .DW    (DW),
        .RW    (RW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ng    (in_ng),
        .in_zr    (in_zr),
        .in_mask  (in_mask),
        .in_rd    (in_rd),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_vreg  (wr_vreg),
        .wr_lane  (wr_lane),
        .wr_data  (wr_data),
        .fl_we    (fl_we),
        .fl_ng    (fl_ng),
        .fl_zr    (fl_zr),
        .busy     (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  mask;
        logic [31:0] base;
        logic [7:0]  ng;
        logic [7:0]  zr;
        logic [4:0]  rd;
        int          stall;
        logic [7:0]  e_ng;
        logic [7:0]  e_zr;
        logic [31:0] e_order;
        int          e_n;
        int          e_fl;
    } vec_t;

    vec_t tbl [6];

    // Reference model: enabled lanes in ascending order, packed one nibble per write.
    function automatic logic [31:0] model_order(input logic [7:0] mask);
        logic [31:0] o = '0;
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                o = o | (32'(i) << (4 * n));
                n++;
            end
        end
        return o;
    endfunction

    // Cycle of the flag strobe: one cycle after the k-th accepted write.
    function automatic int model_fl_cycle(input logic [7:0] mask, input logic [63:0] pat);
        int k = $countones(mask);
        int cnt = 0;
        if (k == 0) return 1;
        for (int c = 1; c < 64; c++) begin
            if (pat[c]) begin
                cnt++;
                if (cnt == k) return c + 1;
            end
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input logic [7:0] mask, input logic [255:0] data,
                           input logic [7:0] ng, input logic [7:0] zr, input logic [4:0] rd,
                           input logic [63:0] pat,
                           output logic [31:0] o_order, output int o_n,
                           output logic [7:0] o_ng, output logic [7:0] o_zr,
                           output int o_flcnt, output int o_flcyc, output int o_rdycyc);
        bit          stalled = 1'b0;
        logic [2:0]  p_lane = '0;
        logic [31:0] p_data = '0;
        logic [4:0]  p_vreg = '0;
        o_order = '0; o_n = 0; o_ng = '0; o_zr = '0;
        o_flcnt = 0; o_flcyc = -1; o_rdycyc = -1;
        for (int w = 0; w < 100 && !in_ready; w++) step();
        in_valid = 1'b1; in_data = data; in_mask = mask;
        in_ng = ng; in_zr = zr; in_rd = rd; wr_ready = 1'b0;
        step();
        // Keep in_valid high with junk while busy: it must be ignored.
        in_data = {8{$urandom}};
        in_mask = 8'($urandom); in_ng = 8'($urandom); in_zr = 8'($urandom);
        in_rd = 5'($urandom);
        for (int c = 1; c < 64; c++) begin
            wr_ready = pat[c];
            if (in_ready) begin
                in_valid = 1'b0;
                o_rdycyc = c;
                break;
            end
            chk("busy_while_active", busy, 1);
            if (stalled) begin
                chk("stall_valid_held", wr_valid, 1);
                chk("stall_lane_held", wr_lane, p_lane);
                chk("stall_data_held", wr_data, p_data);
                chk("stall_vreg_held", wr_vreg, p_vreg);
            end
            if (wr_valid) begin
                if (wr_ready) begin
                    chk("wr_data", wr_data, data[int'(wr_lane)*32 +: 32]);
                    chk("wr_vreg", wr_vreg, rd);
                    if (o_n < 8) o_order = o_order | (32'(wr_lane) << (4 * o_n));
                    o_n++;
                end
                stalled = !wr_ready;
                p_lane = wr_lane; p_data = wr_data; p_vreg = wr_vreg;
            end else begin
                stalled = 1'b0;
            end
            if (fl_we) begin
                o_flcnt++;
                o_flcyc = c;
                o_ng = fl_ng;
                o_zr = fl_zr;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [255:0] ramp(input logic [31:0] base);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = base + 32'(i);
        return d;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0]  o_order;
        int           o_n, o_flcnt, o_flcyc, o_rdycyc;
        logic [7:0]   o_ng, o_zr;
        logic [63:0]  pat;
        logic [255:0] data;
        logic [255:0] data_b;
        logic [7:0]   mask, ng, zr;
        logic [4:0]   rd;
        int           cnt_wv, cnt_fl, b_acc, n_hs;
        logic [31:0]  ord;
        logic [7:0]   fl_first, fl_second;

        tbl[0] = '{mask: 8'hFF, base: 32'h1000_0000, ng: 8'h0F, zr: 8'h80, rd: 5'd5,  stall: 0,
                   e_ng: 8'h0F, e_zr: 8'h80, e_order: 32'h7654_3210, e_n: 8, e_fl: 9};
        tbl[1] = '{mask: 8'hA4, base: 32'h2000_0000, ng: 8'hFF, zr: 8'h00, rd: 5'd9,  stall: 0,
                   e_ng: 8'hA4, e_zr: 8'h00, e_order: 32'h0000_0752, e_n: 3, e_fl: 4};
        tbl[2] = '{mask: 8'h00, base: 32'h3000_0000, ng: 8'h0F, zr: 8'hFF, rd: 5'd1,  stall: 0,
                   e_ng: 8'h00, e_zr: 8'h00, e_order: 32'h0000_0000, e_n: 0, e_fl: 1};
        tbl[3] = '{mask: 8'h03, base: 32'h4000_0000, ng: 8'h01, zr: 8'h02, rd: 5'd31, stall: 3,
                   e_ng: 8'h01, e_zr: 8'h02, e_order: 32'h0000_0010, e_n: 2, e_fl: 6};
        tbl[4] = '{mask: 8'h80, base: 32'h5000_0000, ng: 8'h80, zr: 8'h80, rd: 5'd17, stall: 0,
                   e_ng: 8'h80, e_zr: 8'h80, e_order: 32'h0000_0007, e_n: 1, e_fl: 2};
        tbl[5] = '{mask: 8'h5A, base: 32'h6000_0000, ng: 8'h3C, zr: 8'hC3, rd: 5'd12, stall: 0,
                   e_ng: 8'h18, e_zr: 8'h42, e_order: 32'h0000_6431, e_n: 4, e_fl: 5};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ng = '0; in_zr = '0;
        in_mask = '0; in_rd = '0; wr_ready = 1'b0;
        step(); step(); step();
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_fl_we", fl_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_lane", wr_lane, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_vreg", wr_vreg, 0);
        chk("rst_fl_ng", fl_ng, 0);
        chk("rst_fl_zr", fl_zr, 0);
        rst_n = 1'b1;
        step();

        for (int t = 0; t < 6; t++) begin
            pat = ~((64'd1 << (tbl[t].stall + 1)) - 64'd1);
            run_vec(tbl[t].mask, ramp(tbl[t].base), tbl[t].ng, tbl[t].zr, tbl[t].rd, pat,
                    o_order, o_n, o_ng, o_zr, o_flcnt, o_flcyc, o_rdycyc);
            chk($sformatf("tbl%0d_order", t), o_order, tbl[t].e_order);
            chk($sformatf("tbl%0d_nwrites", t), o_n, tbl[t].e_n);
            chk($sformatf("tbl%0d_fl_count", t), o_flcnt, 1);
            chk($sformatf("tbl%0d_fl_ng", t), o_ng, tbl[t].e_ng);
            chk($sformatf("tbl%0d_fl_zr", t), o_zr, tbl[t].e_zr);
            chk($sformatf("tbl%0d_fl_cycle", t), o_flcyc, tbl[t].e_fl);
            chk($sformatf("tbl%0d_ready_cycle", t), o_rdycyc, tbl[t].e_fl + 1);
        end

        // Reset in the middle of draining an 8-lane vector.
        in_valid = 1'b1; in_data = ramp(32'h7000_0000); in_mask = 8'hFF;
        in_ng = 8'hFF; in_zr = 8'hFF; in_rd = 5'd3; wr_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("mid_pre_valid", wr_valid, 1);
        chk("mid_pre_lane", wr_lane, 2);
        rst_n = 1'b0;
        step();
        chk("mid_rst_wr_valid", wr_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        cnt_wv = 0; cnt_fl = 0;
        for (int c = 0; c < 12; c++) begin
            if (wr_valid) cnt_wv++;
            if (fl_we) cnt_fl++;
            step();
        end
        chk("mid_rst_no_writes", cnt_wv, 0);
        chk("mid_rst_no_fl_we", cnt_fl, 0);
        pat = ~64'd1;
        run_vec(8'hFF, ramp(32'h1000_0000), 8'h0F, 8'h80, 5'd5, pat,
                o_order, o_n, o_ng, o_zr, o_flcnt, o_flcyc, o_rdycyc);
        chk("post_rst_order", o_order, 32'h7654_3210);
        chk("post_rst_fl_ng", o_ng, 8'h0F);
        chk("post_rst_fl_cycle", o_flcyc, 9);

        // Back-to-back: in_valid stays high across two vectors.
        data = ramp(32'hA000_0000);
        data_b = ramp(32'hB000_0000);
        wr_ready = 1'b1;
        in_valid = 1'b1; in_data = data; in_mask = 8'h01;
        in_ng = 8'hFF; in_zr = 8'h00; in_rd = 5'd7;
        step();
        in_data = data_b; in_mask = 8'h80; in_ng = 8'hFF; in_zr = 8'hFF; in_rd = 5'd8;
        b_acc = -1; n_hs = 0; ord = '0; cnt_fl = 0; fl_first = '0; fl_second = '0;
        for (int c = 1; c < 16; c++) begin
            if (wr_valid && wr_ready) begin
                chk("b2b_wr_data", wr_data,
                    (wr_lane == 3'd0) ? data[31:0] : data_b[int'(wr_lane)*32 +: 32]);
                if (n_hs < 8) ord = ord | (32'(wr_lane) << (4 * n_hs));
                n_hs++;
            end
            if (fl_we) begin
                if (cnt_fl == 0) fl_first = fl_ng;
                else fl_second = fl_ng;
                cnt_fl++;
            end
            if (in_ready && in_valid && b_acc < 0) begin
                b_acc = c;
                step();
                in_valid = 1'b0;
            end else begin
                step();
            end
        end
        chk("b2b_accept_cycle", b_acc, 3);
        chk("b2b_order", ord, 32'h70);
        chk("b2b_nwrites", n_hs, 2);
        chk("b2b_fl_pulses", cnt_fl, 2);
        chk("b2b_fl_ng_first", fl_first, 8'h01);
        chk("b2b_fl_ng_second", fl_second, 8'h80);

        // Randomized vectors with random write-port backpressure.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 8; i++) data[i*32 +: 32] = $urandom;
            case ($urandom_range(0, 5))
                0:       mask = 8'h00;
                1:       mask = 8'hFF;
                default: mask = 8'($urandom);
            endcase
            ng = 8'($urandom); zr = 8'($urandom); rd = 5'($urandom);
            pat = {$urandom, $urandom};
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 3) != 0 || i >= 32) pat[i] = 1'b1;
            end
            run_vec(mask, data, ng, zr, rd, pat,
                    o_order, o_n, o_ng, o_zr, o_flcnt, o_flcyc, o_rdycyc);
            chk($sformatf("rnd%0d_order", r), o_order, model_order(mask));
            chk($sformatf("rnd%0d_nwrites", r), o_n, $countones(mask));
            chk($sformatf("rnd%0d_fl_count", r), o_flcnt, 1);
            chk($sformatf("rnd%0d_fl_ng", r), o_ng, ng & mask);
            chk($sformatf("rnd%0d_fl_zr", r), o_zr, zr & mask);
            chk($sformatf("rnd%0d_fl_cycle", r), o_flcyc, model_fl_cycle(mask, pat));
            chk($sformatf("rnd%0d_ready_cycle", r), o_rdycyc, model_fl_cycle(mask, pat) + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_writeback.md
# vec_writeback

Writeback stage directly downstream of the 8-lane vector ALU. It captures one complete vector result: 8 lanes of 32-bit data, per-lane negative/zero flags, a lane mask and a destination vector register. It then serializes the enabled lanes, one 32-bit lane per accepted handshake, into the vector register file's single write port. It finishes by committing the masked flag vectors to the flag register in one cycle.

## Interface
Parameters:
- LANES, 8, lanes per vector (matches ALU width)
- DW, 32, bits per lane
- RW, 5, destination vector-register index width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  block can accept a result
- in_data  in  LANES*DW  lane i at bits [i*DW +: DW]
- in_ng  in  LANES  per-lane negative flags
- in_zr  in  LANES  per-lane zero flags
- in_mask  in  LANES  lane write enables
- in_rd  in  RW  destination vector register
- wr_valid  out  1  register-file write request
- wr_ready  in  1  register file accepts write
- wr_vreg  out  RW  destination register
- wr_lane  out  3  lane index being written
- wr_data  out  DW  lane data
- fl_we  out  1  one-cycle flag-register write strobe
- fl_ng  out  LANES  committed negative flags
- fl_zr  out  LANES  committed zero flags
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, DRAIN, FLAG.
- IDLE:
  - in_ready=1.
  - On in_valid, register in_data, in_ng, in_zr, in_rd and in_mask. The registered mask becomes the pending mask.
  - Go to DRAIN if in_mask≠0, otherwise go to FLAG.
- DRAIN:
  - wr_valid=1.
  - wr_lane = lowest set bit of the pending mask; wr_data = that lane's word; wr_vreg = captured rd.
  - On wr_ready, clear that pending bit.
  - If that was the last pending bit, go to FLAG; otherwise stay in DRAIN and present the next lane the following cycle.
  - While wr_ready=0, wr_lane/wr_data/wr_vreg stay stable.
- FLAG:
  - fl_we=1 for exactly one cycle.
  - fl_ng = captured ng & captured mask; fl_zr = captured zr & captured mask.
  - Then go to IDLE.
- Masked-off lanes are never written, and their flags commit as 0.
- in_ready=0 in DRAIN and FLAG. Upstream must hold its result until accepted.

## Timing
- Reset values (rst_n=0 at an edge):
  - State IDLE; pending mask 0.
  - wr_valid=0, fl_we=0, busy=0, in_ready=1.
  - wr_lane=0, wr_data=0, wr_vreg=0, fl_ng=0, fl_zr=0.
- Reset mid-DRAIN or mid-FLAG aborts the vector. No further writes or fl_we occur for it.
- With k enabled lanes and wr_ready tied high:
  - Accept at edge 0.
  - Writes occupy cycles 1..k.
  - fl_we is asserted in cycle k+1.
  - in_ready rises in cycle k+2.
- Throughput is k+2 cycles per vector; k=0 gives 2 cycles.
- wr_ready stalls extend DRAIN cycle-for-cycle. A stall never reorders lanes and never skips FLAG.
- Lanes are always written in ascending index order.
- in_valid while in_ready=0 is ignored (no capture, no error).
- All outputs are registered or decoded from state only. There is no combinational path from in_* to any output.

## Structure
- Shared package vpu_pkg:
  - LANES, DW, RW constants.
  - wb_state_t enum {IDLE, DRAIN, FLAG}, also reused by later VPU stages.
- One sub-module: lane_prio_enc.
  - Purely combinational, LANES-bit input → 3-bit index of the lowest set bit plus an any-set output.
  - Instantiated once on the pending mask.

## Test plan
- Full mask, wr_ready=1:
  - Stimulus: mask=8'hFF, lane i = 32'h1000_0000+i, ng=8'h0F, zr=8'h80, rd=5.
  - Required: lanes 0..7 written in cycles 1..8 with vreg 5; fl_we in cycle 9 with fl_ng=8'h0F, fl_zr=8'h80; in_ready high in cycle 10.
- Sparse mask:
  - Stimulus: mask=8'b1010_0100.
  - Required: exactly three writes to lanes 2, 5, 7 in that order; with ng=8'hFF, fl_ng=8'hA4.
- Zero mask:
  - Stimulus: mask=0, zr=8'hFF.
  - Required: no wr_valid; fl_we one cycle after accept with fl_zr=0; ready again 2 cycles after accept.
- Backpressure:
  - Stimulus: mask=8'h03, wr_ready low for 3 cycles after the lane-0 request.
  - Required: lane 0 held stable with unchanged data for 4 cycles; lane 1 follows; exactly 2 handshakes.
- Reset mid-DRAIN:
  - Stimulus: rst_n=0 after the 2nd of 8 writes.
  - Required: next cycle wr_valid=0, busy=0, in_ready=1; no fl_we; the next vector is processed normally from lane 0.
- Back-to-back:
  - Stimulus: in_valid held high with two vectors (masks 8'h01 and 8'h80).
  - Required: second vector accepted exactly 3 cycles after the first; writes lane 0 then lane 7; two fl_we pulses.
